sneuron_ctrl: RTL
=================

# sneuron_ctrl

Sequencer for the second-layer neuron multiplier. It accepts a stream of N_IN hidden-layer activations and pairs each one with a locally stored 5-bit weight. It issues one multiply per accepted beat to the external registered multiplier and accumulates the returned 17-bit products. After the last product arrives it presents one signed sum on a valid/ready output.

## Interface
- N_IN, 8: activations (and weights) per evaluation; power of two, 2..16
- ACC_W, 17+$clog2(N_IN): accumulator / result width
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- start  in  1  begin an evaluation; honoured only in IDLE
- soft_clr  in  1  synchronous abort to IDLE, clears accumulator
- w_we  in  1  weight write strobe; honoured only in IDLE
- w_addr  in  $clog2(N_IN)  weight index
- w_data  in  5 signed  weight value
- in_valid  in  1  activation beat valid
- in_data  in  14 signed  activation
- in_ready  out  1  controller can accept a beat
- mul_enable  out  1  multiplier enable (= in_valid & in_ready)
- mul_input  out  14 signed  = in_data
- mul_weight  out  5 signed  = weight[idx]
- mul_product  in  17 signed  multiplier output, one cycle after mul_enable
- out_valid  out  1  result valid
- out_data  out  ACC_W signed  accumulated sum
- out_ready  in  1  result consumer ready
- busy  out  1  high in every state except IDLE

## Operation
- States:
  - IDLE: in_ready=0.
    - w_we writes weight[w_addr] at the clock edge.
    - start clears acc and idx, then moves to RUN.
  - RUN: in_ready=1.
    - Each accept (in_valid & in_ready) increments idx and sets the pending flag for the next cycle.
    - Accept with idx==N_IN-1 moves to DRAIN.
  - DRAIN: in_ready=0; adds the final pending product, then moves to DONE.
  - DONE: out_valid=1 and out_data=acc, both held stable.
    - out_valid & out_ready moves to IDLE.
- Accumulation: when pending=1, acc <= acc + sign_extend(mul_product).
  - mul_product is used as received; any wrap inside the 17-bit multiplier is not corrected.
  - ACC_W guarantees no accumulator overflow for N_IN terms.
- mul_enable, mul_input and mul_weight are combinational from the handshake and idx.
- mul_enable=0 whenever no beat is accepted.
- in_valid while in_ready=0 is ignored; beat gaps in RUN are allowed.
- start outside IDLE is ignored; w_we outside IDLE is ignored (weights are frozen during an evaluation).
- start and w_we in the same IDLE cycle: both take effect; the new weight applies to the evaluation.
- soft_clr has priority over every other input.
  - In any state: go to IDLE, acc=0, idx=0, pending=0, out_valid=0.
  - Weights are retained.
- Reset: state=IDLE, weights=0, acc=0, idx=0, pending=0.
  - All outputs 0: in_ready, mul_enable, mul_input, mul_weight, out_valid, out_data, busy.

## Timing
- start sampled at edge 0 → in_ready=1 from cycle 1.
- Last accept in cycle t → product returns in t+1 (DRAIN) → out_valid=1 in cycle t+2.
- Back-to-back stream: start in cycle 0, accepts in cycles 1..8, DRAIN in cycle 9, out_valid in cycle 10 (N_IN=8).
- out_valid held for any number of cycles until out_ready; the transfer cycle returns to IDLE, so the next start can be sampled one cycle later.
- Throughput: one beat per cycle; no bubbles inserted by the controller in RUN.

## Structure
- Package sneuron_ctrl_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE}
  - IN_W=14, W_W=5, P_W=17
  - ACC_W function of N_IN
- Sub-module sneuron_wbank: N_IN×5 signed register file.
  - Async read at idx; sync write gated by IDLE.
  - Reset to 0.
- Multiplier is external and not instantiated here; the bench models it as a one-cycle registered product, 0 when not enabled.

## Test plan
- Weights all +1, inputs 1..8 back-to-back → out_data=36; out_valid first high 10 cycles after start.
- Weights all +15, inputs all 4000 → out_data=480000. Inputs all −4000 → −480000; checks sign extension.
- Weights 1..8, in_valid toggled 1/0 per cycle → out_data=Σk·in_k matches the model; mul_enable=0 in gap cycles.
- out_ready held low for 5 cycles in DONE → out_data and out_valid stable; a start pulse during DONE is ignored.
- w_we with w_data=−16 during RUN → weight unchanged, result unaffected. The same write in IDLE concurrent with start → the new weight is used.
- soft_clr after 4 accepts → IDLE next cycle, busy=0, no out_valid. A new full evaluation then gives the correct result. n_rst asserted mid-RUN → all outputs 0 immediately and weights=0.

Source files
------------

// File: rtl/sneuron_ctrl_pkg.sv
// Shared types and widths for the second-layer neuron multiplier sequencer.
package sneuron_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int IN_W = 14;
  localparam int W_W  = 5;
  localparam int P_W  = 17;

  // Room for N_IN full-scale products without overflow.
  function automatic int acc_width(input int n_in);
    return P_W + $clog2(n_in);
  endfunction

endpackage

// File: rtl/sneuron_wbank.sv
// Signed weight register file: combinational read, writes accepted only while idle.
module sneuron_wbank
  import sneuron_ctrl_pkg::*;
#(
  parameter int N_IN  = 8,
  parameter int IDX_W = $clog2(N_IN)
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    idle,
  input  logic                    we,
  input  logic [IDX_W-1:0]        waddr,
  input  logic signed [W_W-1:0]   wdata,
  input  logic [IDX_W-1:0]        raddr,
  output logic signed [W_W-1:0]   rdata
);

  logic signed [W_W-1:0] weight_q [N_IN];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < N_IN; i++) begin
        weight_q[i] <= '0;
      end
    end else if (we && idle) begin
      weight_q[waddr] <= wdata;
    end
  end

  assign rdata = weight_q[raddr];

endmodule

// File: rtl/sneuron_ctrl.sv
// Sequences N_IN activation beats through an external registered multiplier
// and accumulates the returned products into one signed result.
module sneuron_ctrl
  import sneuron_ctrl_pkg::*;
#(
  parameter int N_IN  = 8,
  parameter int ACC_W = acc_width(N_IN)
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       start,
  input  logic                       soft_clr,
  input  logic                       w_we,
  input  logic [$clog2(N_IN)-1:0]    w_addr,
  input  logic signed [W_W-1:0]      w_data,
  input  logic                       in_valid,
  input  logic signed [IN_W-1:0]     in_data,
  output logic                       in_ready,
  output logic                       mul_enable,
  output logic signed [IN_W-1:0]     mul_input,
  output logic signed [W_W-1:0]      mul_weight,
  input  logic signed [P_W-1:0]      mul_product,
  output logic                       out_valid,
  output logic signed [ACC_W-1:0]    out_data,
  input  logic                       out_ready,
  output logic                       busy
);

  localparam int IDX_W = $clog2(N_IN);

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     pending_q, pending_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [W_W-1:0]    w_rd;
  logic                     accept;
  logic                     last_beat;

  sneuron_wbank #(.N_IN(N_IN), .IDX_W(IDX_W)) u_wbank (
    .clk   (clk),
    .n_rst (n_rst),
    .idle  (state_q == IDLE),
    .we    (w_we && !soft_clr),
    .waddr (w_addr),
    .wdata (w_data),
    .raddr (idx_q),
    .rdata (w_rd)
  );

  // soft_clr wins over in_valid, so no beat is taken in the abort cycle.
  assign in_ready   = (state_q == RUN) && !soft_clr;
  assign accept     = in_valid && in_ready;
  assign last_beat  = (idx_q == IDX_W'(N_IN - 1));

  assign mul_enable = accept;
  assign mul_input  = accept ? in_data : '0;
  assign mul_weight = accept ? w_rd : '0;

  assign out_valid  = (state_q == DONE);
  assign out_data   = out_valid ? acc_q : '0;
  assign busy       = (state_q != IDLE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      acc_q     <= acc_d;
    end
  end

  // A product is added the cycle after its beat was accepted, which is why
  // DRAIN exists: it collects the product of the final beat.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = accept;
    acc_d     = acc_q;
    if (pending_q) begin
      acc_d = acc_q + {{(ACC_W - P_W){mul_product[P_W-1]}}, mul_product};
    end

    if (soft_clr) begin
      state_d   = IDLE;
      idx_d     = '0;
      pending_d = 1'b0;
      acc_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RUN;
            idx_d   = '0;
            acc_d   = '0;
          end
        end
        RUN: begin
          if (accept) begin
            idx_d = idx_q + IDX_W'(1);
            if (last_beat) begin
              state_d = DRAIN;
            end
          end
        end
        DRAIN: state_d = DONE;
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
